// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, word type, key sequencer FSM states and a
// helper that extracts word i (word 0 in the MSBs) from a 128-bit key.
package aes_pkg;

  localparam int unsigned NR = 10;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWaitDone,
    StReady,
    StFetch,
    StOut
  } ks_state_e;

  function automatic word_t key_word(input logic [127:0] key, input logic [1:0] idx);
    return key[127 - 32*int'(idx) -: 32];
  endfunction

endpackage

// File: rtl/key_sequencer.sv
// Feeds a cipher key word-by-word into key_expand, then hands out assembled round keys
// on request. Define KEY_SEQ_DECRYPT_EN to add a dec input selecting descending order.
module key_sequencer #(
  parameter int unsigned NR        = aes_pkg::NR,
  parameter int unsigned KEY_WORDS = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] key_in,
  input  logic         key_valid,
`ifdef KEY_SEQ_DECRYPT_EN
  input  logic         dec,
`endif
  output logic         key_ready,
  output logic         ke_start,
  output logic [31:0]  ke_cipher_key,
  input  logic         ke_done,
  output logic [3:0]   ke_round_key_num,
  output logic [1:0]   ke_r_index,
  input  logic [31:0]  ke_round_key,
  input  logic         rk_req,
  input  logic         rk_rewind,
  output logic         rk_valid,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         rk_last,
  output logic         busy
);

  import aes_pkg::*;

  localparam logic [3:0] LastRound = 4'(NR);
  localparam logic [1:0] LastWord  = 2'(KEY_WORDS - 1);

  ks_state_e    state_q;
  logic [127:0] key_q;
  logic [127:0] rk_buf_q;
  logic [1:0]   load_cnt_q;
  logic [3:0]   ptr_q;
  logic [3:0]   first_round, last_round, next_ptr;
  logic         dec_q, dec_now;

`ifdef KEY_SEQ_DECRYPT_EN
  assign dec_now = dec;

  always_ff @(posedge clk) begin
    if (reset) begin
      dec_q <= 1'b0;
    end else if (key_valid && key_ready) begin
      dec_q <= dec;
    end
  end
`else
  assign dec_now = 1'b0;
  assign dec_q   = 1'b0;
`endif

  always_comb begin
    first_round = dec_q ? LastRound : 4'd0;
    last_round  = dec_q ? 4'd0 : LastRound;
    if (ptr_q == last_round) begin
      next_ptr = first_round;
    end else begin
      next_ptr = dec_q ? ptr_q - 4'd1 : ptr_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= StIdle;
      key_q            <= '0;
      rk_buf_q         <= '0;
      load_cnt_q       <= '0;
      ptr_q            <= '0;
      key_ready        <= 1'b1;
      ke_start         <= 1'b0;
      ke_cipher_key    <= '0;
      ke_round_key_num <= '0;
      ke_r_index       <= '0;
      rk_valid         <= 1'b0;
      rk_out           <= '0;
      rk_round         <= '0;
      rk_last          <= 1'b0;
      busy             <= 1'b0;
    end else begin
      rk_valid <= 1'b0;
      case (state_q)
        StIdle, StReady: begin
          // Key acceptance wins over rewind, rewind wins over a round-key request.
          if (key_valid) begin
            state_q       <= StLoad;
            key_q         <= key_in;
            load_cnt_q    <= '0;
            ptr_q         <= dec_now ? LastRound : 4'd0;
            key_ready     <= 1'b0;
            busy          <= 1'b1;
            ke_start      <= 1'b1;
            ke_cipher_key <= key_word(key_in, 2'd0);
          end else if (state_q == StReady && rk_rewind) begin
            ptr_q <= first_round;
          end else if (state_q == StReady && rk_req) begin
            state_q          <= StFetch;
            key_ready        <= 1'b0;
            busy             <= 1'b1;
            ke_round_key_num <= ptr_q;
            ke_r_index       <= '0;
          end
        end
        StLoad: begin
          if (load_cnt_q == LastWord) begin
            state_q       <= StWaitDone;
            ke_start      <= 1'b0;
            ke_cipher_key <= '0;
          end else begin
            load_cnt_q    <= load_cnt_q + 2'd1;
            ke_cipher_key <= key_word(key_q, load_cnt_q + 2'd1);
          end
        end
        StWaitDone: begin
          if (ke_done) begin
            state_q   <= StReady;
            key_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        StFetch: begin
          rk_buf_q[127 - 32*int'(ke_r_index) -: 32] <= ke_round_key;
          if (ke_r_index == LastWord) begin
            state_q          <= StOut;
            ke_round_key_num <= '0;
            ke_r_index       <= '0;
          end else begin
            ke_r_index <= ke_r_index + 2'd1;
          end
        end
        StOut: begin
          rk_valid  <= 1'b1;
          rk_out    <= rk_buf_q;
          rk_round  <= ptr_q;
          rk_last   <= (ptr_q == last_round);
          ptr_q     <= next_ptr;
          state_q   <= StReady;
          key_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_key_sequencer.sv
// Bench for key_sequencer: behavioural AES key_expand stand-in, timeline reference model,
// per-cycle compare process, directed literal scenarios and a randomized phase.
module tb_key_sequencer;

  logic         clk = 1'b0;
  logic         reset, key_valid, ke_done, rk_req, rk_rewind;
  logic [127:0] key_in;
  logic         key_ready, ke_start, rk_valid, rk_last, busy;
  logic [31:0]  ke_cipher_key, ke_round_key;
  logic [3:0]   ke_round_key_num, rk_round;
  logic [1:0]   ke_r_index;
  logic [127:0] rk_out;

  always #5 clk = ~clk;

  key_sequencer dut (
    .clk(clk), .reset(reset), .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
    .ke_start(ke_start), .ke_cipher_key(ke_cipher_key), .ke_done(ke_done),
    .ke_round_key_num(ke_round_key_num), .ke_r_index(ke_r_index),
    .ke_round_key(ke_round_key), .rk_req(rk_req), .rk_rewind(rk_rewind),
    .rk_valid(rk_valid), .rk_out(rk_out), .rk_round(rk_round), .rk_last(rk_last),
    .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- AES key schedule from first principles ----------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (gf_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      end
      sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
    logic [31:0] w0, w1, w2, w3, t;
    logic [7:0]  rc;
    {w0, w1, w2, w3} = key;
    rc = 8'h01;
    for (int i = 1; i <= r; i++) begin
      t  = {w3[23:0], w3[31:24]};
      t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      rc = xtime(rc);
    end
    return {w0, w1, w2, w3};
  endfunction

  // ---------------- key_expand stand-in: collects start words, done after a delay ---------
  logic [31:0]  ke_cap [4];
  logic [127:0] ke_tab [11];
  int           ke_cnt, ke_delay;
  logic         ke_counting;

  always @(posedge clk) begin
    if (reset) begin
      ke_cnt      <= 0;
      ke_done     <= 1'b0;
      ke_counting <= 1'b0;
      ke_delay    <= 0;
    end else if (ke_start) begin
      ke_done        <= 1'b0;
      ke_cap[ke_cnt] <= ke_cipher_key;
      if (ke_cnt == 3) begin
        for (int r = 0; r <= 10; r++)
          ke_tab[r] <= round_key({ke_cap[0], ke_cap[1], ke_cap[2], ke_cipher_key}, r);
        ke_cnt      <= 0;
        ke_delay    <= int'($urandom_range(1, 6));
        ke_counting <= 1'b1;
      end else begin
        ke_cnt <= ke_cnt + 1;
      end
    end else if (ke_counting) begin
      if (ke_delay == 1) begin
        ke_done     <= 1'b1;
        ke_counting <= 1'b0;
      end
      ke_delay <= ke_delay - 1;
    end
  end

  always_comb begin
    ke_round_key = 32'h0;
    if (ke_round_key_num <= 4'd10)
      ke_round_key = ke_tab[ke_round_key_num][127 - 32*int'(ke_r_index) -: 32];
  end

  // ---------------- reference model: timeline of edges ----------------
  bit           m_init = 1'b0;
  bit           m_free, m_keyed, m_wait, m_due_v;
  int           m_edge = 0, m_load_edge, m_due_edge, m_ptr;
  logic [127:0] m_key;
  logic         exp_valid, exp_last, exp_ks;
  logic [127:0] exp_out;
  logic [3:0]   exp_round;
  logic [31:0]  exp_kw;

  task automatic model_edge();
    m_edge++;
    if (reset) begin
      m_init = 1'b1; m_free = 1'b1; m_keyed = 1'b0; m_wait = 1'b0; m_due_v = 1'b0;
      m_ptr = 0; exp_valid = 1'b0; exp_out = '0; exp_round = '0; exp_last = 1'b0;
    end else if (m_init) begin
      exp_valid = 1'b0;
      if (m_due_v && m_edge == m_due_edge) begin
        exp_valid = 1'b1;
        exp_out   = round_key(m_key, m_ptr);
        exp_round = 4'(m_ptr);
        exp_last  = (m_ptr == 10);
        m_ptr     = (m_ptr == 10) ? 0 : m_ptr + 1;
        m_due_v   = 1'b0;
        m_free    = 1'b1;
      end else if (m_free) begin
        if (key_valid) begin
          m_key = key_in; m_ptr = 0; m_free = 1'b0; m_keyed = 1'b0;
          m_wait = 1'b1; m_load_edge = m_edge;
        end else if (m_keyed && rk_rewind) begin
          m_ptr = 0;
        end else if (m_keyed && rk_req) begin
          m_free = 1'b0; m_due_v = 1'b1; m_due_edge = m_edge + 5;
        end
      end else if (m_wait && m_edge >= m_load_edge + 5 && ke_done) begin
        m_wait = 1'b0; m_free = 1'b1; m_keyed = 1'b1;
      end
    end
    exp_ks = m_init && m_wait && (m_edge - m_load_edge) <= 3;
    exp_kw = exp_ks ? m_key[127 - 32*(m_edge - m_load_edge) -: 32] : 32'h0;
  endtask

  always @(negedge clk) begin
    if (m_init) begin
      check("key_ready", key_ready, m_free);
      check("busy", busy, !m_free);
      check("ke_start", ke_start, exp_ks);
      check("ke_cipher_key", ke_cipher_key, exp_kw);
      check("rk_valid", rk_valid, exp_valid);
      check("rk_out", rk_out, exp_out);
      check("rk_round", rk_round, exp_round);
      check("rk_last", rk_last, exp_last);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!key_ready && n < 60) begin
      tick();
      n++;
    end
    check("wait_ready", key_ready, 1'b1);
  endtask

  // Issues one request from READY and returns the cycles until rk_valid.
  task automatic request(output int lat);
    rk_req = 1'b1;
    tick();
    rk_req = 1'b0;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      lat++;
      if (rk_valid) break;
    end
  endtask

  task automatic load_key(input logic [127:0] k);
    key_in = k;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  localparam logic [127:0] K = 128'h54686174_73206D79_204B756E_67204675;

  initial begin
    int lat, pulses;
    reset = 1'b1; key_valid = 1'b0; rk_req = 1'b0; rk_rewind = 1'b0; key_in = '0;
    build_sbox();
    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;
    check("reset_key_ready", key_ready, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_rk_valid", rk_valid, 1'b0);

    // Key words presented in order, one per LOAD cycle.
    load_key(K);
    check("ke_w0", {ke_start, ke_cipher_key}, {1'b1, 32'h54686174});
    tick();
    check("ke_w1", {ke_start, ke_cipher_key}, {1'b1, 32'h73206D79});
    tick();
    check("ke_w2", {ke_start, ke_cipher_key}, {1'b1, 32'h204B756E});
    tick();
    check("ke_w3", {ke_start, ke_cipher_key}, {1'b1, 32'h67204675});
    tick();
    check("ke_start_end", ke_start, 1'b0);
    wait_ready();

    for (int r = 0; r <= 11; r++) begin
      request(lat);
      if (r == 0) begin
        check("r0_latency", lat, 5);
        check("r0_out", rk_out, K);
      end else if (r == 1) begin
        check("r1_latency", lat, 5);
        check("r1_out", rk_out, 128'hE232FCF1_91129188_B159E4E6_D679A293);
      end else if (r == 10) begin
        check("r10_out", rk_out, 128'h28FDDEF8_6DA4244A_CCC0A4FE_3B316F26);
        check("r10_round_last", {rk_round, rk_last}, {4'd10, 1'b1});
      end else if (r == 11) begin
        check("wrap_round", {rk_round, rk_last}, {4'd0, 1'b0});
        check("wrap_out", rk_out, K);
      end
    end

    // Request held into FETCH: only one pulse.
    rk_req = 1'b1;
    tick();
    tick();
    rk_req = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rk_valid) pulses++;
    end
    check("fetch_req_pulses", pulses, 1);

    // Requests during LOAD/WAIT_DONE are dropped.
    key_in = K; key_valid = 1'b1; rk_req = 1'b1;
    tick();
    key_valid = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rk_valid) pulses++;
    end
    rk_req = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (rk_valid) pulses++;
    end
    check("wait_req_pulses", pulses, 0);

    // Reset in the second LOAD cycle, then reload.
    load_key(K);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_load_outs", {ke_start, ke_cipher_key, ke_round_key_num, ke_r_index, rk_valid,
                            busy}, '0);
    check("mid_load_rk", {rk_out, rk_round, rk_last}, '0);
    check("mid_load_ready", key_ready, 1'b1);
    load_key(K);
    wait_ready();
    request(lat);
    request(lat);
    check("reload_r1", rk_out, 128'hE232FCF1_91129188_B159E4E6_D679A293);

    // Randomized phase.
    for (int c = 0; c < 2500; c++) begin
      reset     = ($urandom_range(0, 399) == 0);
      key_valid = ($urandom_range(0, 39) == 0);
      key_in    = {$urandom, $urandom, $urandom, $urandom};
      rk_req    = ($urandom_range(0, 2) == 0);
      rk_rewind = ($urandom_range(0, 24) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
